// File: rtl/uart_tx_fifo_if.sv
// Producer/transmitter-facing signal bundle of the UART transmit byte queue.
// Optional occupancy output is present only when UART_TXQ_LEVEL_EN is defined.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic              o_Overflow;
    logic              o_Busy;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;
`ifdef UART_TXQ_LEVEL_EN
    logic [ADDR_W:0]   o_Level;
`endif

    // master: producer plus transmitter side; slave: the queue itself
    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
`ifdef UART_TXQ_LEVEL_EN
        input  o_Level,
`endif
        input  o_Full, o_Empty, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
`ifdef UART_TXQ_LEVEL_EN
        output o_Level,
`endif
        output o_Full, o_Empty, o_Overflow, o_Busy, o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter one frame at a time, paced by its Active/Done.
// Define UART_TXQ_LEVEL_EN to expose the registered occupancy on bus.o_Level.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          i_Clock,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_ACT = 3'd2,
        WAIT_END = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic              push;
    logic              pop;
    logic              full_q;
    logic              empty_q;
    logic              ovf_q;
    logic              busy_q;
    logic              tx_dv_q;
    logic [7:0]        tx_byte_q;

    // Room is judged on the pre-edge count, so a same-cycle pop never admits a push at full.
    assign push = bus.i_Wr_DV && (count != FULL_CNT);
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (push && !rst) begin
            mem[wr_ptr] <= bus.i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nxt;
            full_q  <= (count_nxt == FULL_CNT);
            empty_q <= (count_nxt == '0);
            ovf_q   <= bus.i_Wr_DV && !push;
        end
    end

    // WAIT_CLR holds off the next launch until Done drops: the transmitter ignores
    // DV during its cleanup cycle, so launching earlier would lose the byte.
    always_ff @(posedge i_Clock) begin
        if (rst) begin
            state     <= IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte_q <= mem[rd_ptr];
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tx_dv_q <= 1'b0;
                    state   <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (bus.i_Tx_Active) state <= WAIT_END;
                end
                WAIT_END: begin
                    if (bus.i_Tx_Done) state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!bus.i_Tx_Done) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_dv_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Full     = full_q;
    assign bus.o_Empty    = empty_q;
    assign bus.o_Overflow = ovf_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_Tx_DV    = tx_dv_q;
    assign bus.o_Tx_Byte  = tx_byte_q;

`ifdef UART_TXQ_LEVEL_EN
    logic [ADDR_W:0] level_q;

    always_ff @(posedge i_Clock) begin
        if (rst) level_q <= '0;
        else     level_q <= count_nxt;
    end

    assign bus.o_Level = level_q;
`endif

endmodule
